// File: rtl/komandara_axi4_pkg.sv
// Shared AXI4 types for the komandara AXI slaves.
// Provides burst/response encodings, ARLEN/ARSIZE field types, the read-slave
// FSM state type and a WRAP burst-length legality check.
package komandara_axi4_pkg;

    typedef logic [7:0] axi_len_t;
    typedef logic [2:0] axi_size_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] AXI_BURST_RSVD = 2'b11;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'b00,
        RD_ISSUE = 2'b01,
        RD_ERR   = 2'b10
    } rd_state_e;

    // WRAP bursts must be 2, 4, 8 or 16 beats long.
    function automatic logic axi_wrap_len_ok(input axi_len_t len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/komandara_axi4_burst_addr.sv
// Per-beat AXI address generator.
// Ports: clk_i/rst_ni; load_i latches start_addr_i/len_i/size_i/burst_i;
// advance_i steps to the next beat address; addr_o is the current beat address.
module komandara_axi4_burst_addr
    import komandara_axi4_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  axi_len_t          len_i,
    input  axi_size_t         size_i,
    input  logic [1:0]        burst_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] mask_q;
    axi_size_t         size_q;
    axi_burst_e        burst_q;

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] next_addr;

    // Next address: FIXED holds, INCR aligns then steps, WRAP stays inside the span.
    always_comb begin
        step      = ADDR_W'(1) << size_q;
        next_addr = cur_q;
        unique case (burst_q)
            AXI_BURST_INCR: next_addr = (cur_q & ~(step - ADDR_W'(1))) + step;
            AXI_BURST_WRAP: next_addr = (cur_q & ~mask_q) | ((cur_q + step) & mask_q);
            default:        next_addr = cur_q;
        endcase
    end

    // Wrap mask is span-1 with span = beats << size, captured once per burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_q   <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            burst_q <= AXI_BURST_FIXED;
        end else if (load_i) begin
            cur_q   <= start_addr_i;
            mask_q  <= ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
            size_q  <= size_i;
            burst_q <= axi_burst_e'(burst_i);
        end else if (advance_i) begin
            cur_q   <= next_addr;
        end
    end

    assign addr_o = cur_q;

endmodule

// File: rtl/komandara_axi4_rd_slave.sv
// AXI4 read-channel slave front end.
// Accepts AR bursts, issues one single-beat read per cycle to an SRAM-style port
// with 1-cycle latency, and returns R beats through a 2-entry response FIFO.
// Ports: AR channel (ar_*), R channel (r_*), memory port (mem_*), clk_i, rst_ni.
module komandara_axi4_rd_slave
    import komandara_axi4_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ID_W-1:0]   ar_id_i,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic [7:0]        ar_len_i,
    input  logic [2:0]        ar_size_i,
    input  logic [1:0]        ar_burst_i,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    output logic [ID_W-1:0]   r_id_o,
    output logic [DATA_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_last_o,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);

    rd_state_e state_q, state_d;

    logic [ID_W-1:0] id_q;
    axi_len_t        len_q;
    axi_len_t        beat_q;

    logic            pending_q;
    logic [ID_W-1:0] pend_id_q;
    logic            pend_last_q;

    logic [ID_W-1:0]   fifo_id_q   [2];
    logic [DATA_W-1:0] fifo_data_q [2];
    axi_resp_e         fifo_resp_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic ar_hs, ar_legal, last_beat, pop, push, credit_ok, err_push;

    assign ar_hs     = ar_valid_i & ar_ready_o;
    assign ar_legal  = (ar_burst_i != AXI_BURST_RSVD)
                     && (ar_size_i <= axi_size_t'(MAX_SIZE))
                     && !((ar_burst_i == AXI_BURST_WRAP) && !axi_wrap_len_ok(ar_len_i));
    assign last_beat = (beat_q == len_q);
    assign r_valid_o = (count_q != 2'd0);
    assign pop       = r_valid_o & r_ready_i;
    assign push      = pending_q | err_push;

    // Occupancy plus the in-flight beat, net of this cycle's pop, must leave a free slot.
    assign credit_ok = ({1'b0, count_q} + {2'b00, pending_q}) < (3'd2 + {2'b00, pop});

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RD_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (ar_hs) state_d = ar_legal ? RD_ISSUE : RD_ERR;
            RD_ISSUE: if (mem_req_o && last_beat) state_d = RD_IDLE;
            RD_ERR:   if (err_push && last_beat) state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ar_ready_o = 1'b0;
        mem_req_o  = 1'b0;
        err_push   = 1'b0;
        unique case (state_q)
            RD_IDLE:  ar_ready_o = 1'b1;
            RD_ISSUE: mem_req_o  = credit_ok;
            RD_ERR:   err_push   = credit_ok;
            default:  ar_ready_o = 1'b0;
        endcase
    end

    // Burst bookkeeping and the one-deep memory response pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q        <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            pending_q   <= 1'b0;
            pend_id_q   <= '0;
            pend_last_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_q   <= ar_id_i;
                len_q  <= ar_len_i;
                beat_q <= '0;
            end else if (mem_req_o || err_push) begin
                beat_q <= beat_q + 8'd1;
            end
            pending_q   <= mem_req_o;
            pend_id_q   <= id_q;
            pend_last_q <= last_beat;
        end
    end

    // Two-entry response FIFO; the head entry drives the R channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                fifo_id_q[i]   <= '0;
                fifo_data_q[i] <= '0;
                fifo_resp_q[i] <= AXI_RESP_OKAY;
                fifo_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q]   <= pending_q ? pend_id_q : id_q;
                fifo_data_q[wr_ptr_q] <= pending_q ? mem_rdata_i : '0;
                fifo_resp_q[wr_ptr_q] <= (pending_q && !mem_err_i) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                fifo_last_q[wr_ptr_q] <= pending_q ? pend_last_q : last_beat;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign r_id_o   = fifo_id_q[rd_ptr_q];
    assign r_data_o = fifo_data_q[rd_ptr_q];
    assign r_resp_o = fifo_resp_q[rd_ptr_q];
    assign r_last_o = fifo_last_q[rd_ptr_q];

    komandara_axi4_burst_addr #(
        .ADDR_W (ADDR_W)
    ) u_burst_addr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (ar_hs),
        .start_addr_i (ar_addr_i),
        .len_i        (ar_len_i),
        .size_i       (ar_size_i),
        .burst_i      (ar_burst_i),
        .advance_i    (mem_req_o),
        .addr_o       (mem_addr_o)
    );

endmodule

// File: tb/tb_komandara_axi4_rd_slave.sv
// Directed bench for komandara_axi4_rd_slave: a small memory model returns
// addr ^ 0xA5A50000 one cycle after each request; monitors log requests and R beats.
module tb_komandara_axi4_rd_slave;

    localparam logic [31:0] DXOR = 32'hA5A5_0000;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [3:0]  ar_id_i;
    logic [31:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [2:0]  ar_size_i;
    logic [1:0]  ar_burst_i;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [3:0]  r_id_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic        r_valid_o;
    logic        r_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_q [$];
    int          cyc_q [$];
    beat_t       r_q   [$];
    int          cyc = 0;
    int          n_req = 0;
    int          n_pop = 0;
    int          viol = 0;
    int          err_at = -1;
    logic [31:0] nxt_data = '0;
    logic        nxt_err = 1'b0;

    komandara_axi4_rd_slave dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .ar_id_i     (ar_id_i),
        .ar_addr_i   (ar_addr_i),
        .ar_len_i    (ar_len_i),
        .ar_size_i   (ar_size_i),
        .ar_burst_i  (ar_burst_i),
        .ar_valid_i  (ar_valid_i),
        .ar_ready_o  (ar_ready_o),
        .r_id_o      (r_id_o),
        .r_data_o    (r_data_o),
        .r_resp_o    (r_resp_o),
        .r_last_o    (r_last_o),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: log requests/beats, prepare the memory response, track outstanding beats.
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (!rst_ni) begin
            n_req = 0;
            n_pop = 0;
            nxt_data = '0;
            nxt_err = 1'b0;
        end else begin
            if (ar_valid_i && ar_ready_o) begin
                n_req = 0;
                n_pop = 0;
            end
            if (mem_req_o) begin
                if (n_req - n_pop - ((r_valid_o && r_ready_i) ? 1 : 0) >= 2) viol = viol + 1;
                mem_q.push_back(mem_addr_o);
                cyc_q.push_back(cyc);
                nxt_data = mem_addr_o ^ DXOR;
                nxt_err = (n_req == err_at);
                n_req = n_req + 1;
            end else begin
                nxt_data = '0;
                nxt_err = 1'b0;
            end
            if (r_valid_o && r_ready_i) begin
                r_q.push_back({r_id_o, r_data_o, r_resp_o, r_last_o});
                n_pop = n_pop + 1;
            end
        end
    end

    // Memory model: response visible for the whole cycle after the request.
    always @(posedge clk_i) begin
        #1;
        mem_rdata_i = nxt_data;
        mem_err_i = nxt_err;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_addr(input string tag, input int idx, input logic [31:0] exp);
        if (idx < mem_q.size()) check(tag, mem_q[idx], exp);
        else check({tag, "_missing"}, 32'(mem_q.size()), 32'(idx + 1));
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [3:0] id,
                              input logic [31:0] data, input logic [1:0] resp, input logic last);
        beat_t b;
        if (idx < r_q.size()) begin
            b = r_q[idx];
            check({tag, "_id"}, 32'(b.id), 32'(id));
            check({tag, "_data"}, b.data, data);
            check({tag, "_resp"}, 32'(b.resp), 32'(resp));
            check({tag, "_last"}, 32'(b.last), 32'(last));
        end else begin
            check({tag, "_missing"}, 32'(r_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic got;
        got = 1'b0;
        ar_id_i = id;
        ar_addr_i = addr;
        ar_len_i = len;
        ar_size_i = size;
        ar_burst_i = burst;
        ar_valid_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_i);
            if (ar_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        check("ar_accept", 32'(got), 32'd1);
        @(posedge clk_i);
        #1;
        ar_valid_i = 1'b0;
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int n,
                             input bit toggle);
        mem_q.delete();
        cyc_q.delete();
        r_q.delete();
        send_ar(id, addr, len, size, burst);
        for (int c = 0; c < 400 && r_q.size() < n; c++) begin
            @(posedge clk_i);
            #1;
            if (toggle) r_ready_i = ~r_ready_i;
        end
        r_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("beat_count", 32'(r_q.size()), 32'(n));
    endtask

    initial begin
        rst_ni = 1'b0;
        ar_id_i = '0;
        ar_addr_i = '0;
        ar_len_i = '0;
        ar_size_i = '0;
        ar_burst_i = '0;
        ar_valid_i = 1'b0;
        r_ready_i = 1'b1;
        mem_rdata_i = '0;
        mem_err_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_ar_ready", 32'(ar_ready_o), 32'd1);
        check("rst_r_valid", 32'(r_valid_o), 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_ar_ready", 32'(ar_ready_o), 32'd1);
        check("post_rst_mem_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i);
        #1;

        // INCR 0x100 len=3 size=2
        run_burst(4'h3, 32'h100, 8'd3, 3'd2, 2'b01, 4, 1'b0);
        check("incr_nreq", 32'(mem_q.size()), 32'd4);
        check_addr("incr_a0", 0, 32'h100);
        check_addr("incr_a1", 1, 32'h104);
        check_addr("incr_a2", 2, 32'h108);
        check_addr("incr_a3", 3, 32'h10C);
        for (int i = 1; i < 4 && i < cyc_q.size(); i++)
            check("incr_back_to_back", 32'(cyc_q[i] - cyc_q[i-1]), 32'd1);
        check_beat("incr_b0", 0, 4'h3, 32'hA5A5_0100, 2'b00, 1'b0);
        check_beat("incr_b1", 1, 4'h3, 32'hA5A5_0104, 2'b00, 1'b0);
        check_beat("incr_b2", 2, 4'h3, 32'hA5A5_0108, 2'b00, 1'b0);
        check_beat("incr_b3", 3, 4'h3, 32'hA5A5_010C, 2'b00, 1'b1);

        // WRAP 0x1C len=3 size=2
        run_burst(4'h5, 32'h1C, 8'd3, 3'd2, 2'b10, 4, 1'b0);
        check_addr("wrap_a0", 0, 32'h1C);
        check_addr("wrap_a1", 1, 32'h10);
        check_addr("wrap_a2", 2, 32'h14);
        check_addr("wrap_a3", 3, 32'h18);
        check_beat("wrap_b0", 0, 4'h5, 32'hA5A5_001C, 2'b00, 1'b0);
        check_beat("wrap_b1", 1, 4'h5, 32'hA5A5_0010, 2'b00, 1'b0);
        check_beat("wrap_b3", 3, 4'h5, 32'hA5A5_0018, 2'b00, 1'b1);

        // FIXED 0x40 len=2, RID echo
        run_burst(4'hA, 32'h40, 8'd2, 3'd2, 2'b00, 3, 1'b0);
        check_addr("fixed_a0", 0, 32'h40);
        check_addr("fixed_a1", 1, 32'h40);
        check_addr("fixed_a2", 2, 32'h40);
        check_beat("fixed_b0", 0, 4'hA, 32'hA5A5_0040, 2'b00, 1'b0);
        check_beat("fixed_b1", 1, 4'hA, 32'hA5A5_0040, 2'b00, 1'b0);
        check_beat("fixed_b2", 2, 4'hA, 32'hA5A5_0040, 2'b00, 1'b1);

        // Reserved burst type -> 2 SLVERR beats, no memory access
        run_burst(4'h1, 32'h80, 8'd1, 3'd2, 2'b11, 2, 1'b0);
        check("rsvd_nreq", 32'(mem_q.size()), 32'd0);
        check_beat("rsvd_b0", 0, 4'h1, 32'h0, 2'b10, 1'b0);
        check_beat("rsvd_b1", 1, 4'h1, 32'h0, 2'b10, 1'b1);

        // WRAP with len=2 is illegal -> 3 SLVERR beats
        run_burst(4'h2, 32'h20, 8'd2, 3'd2, 2'b10, 3, 1'b0);
        check("wrapbad_nreq", 32'(mem_q.size()), 32'd0);
        check_beat("wrapbad_b0", 0, 4'h2, 32'h0, 2'b10, 1'b0);
        check_beat("wrapbad_b2", 2, 4'h2, 32'h0, 2'b10, 1'b1);

        // Oversized beat (8 bytes on a 4-byte bus) -> single SLVERR beat
        run_burst(4'hB, 32'h60, 8'd0, 3'd3, 2'b01, 1, 1'b0);
        check("size_nreq", 32'(mem_q.size()), 32'd0);
        check_beat("size_b0", 0, 4'hB, 32'h0, 2'b10, 1'b1);

        // INCR len=7 with r_ready toggling
        run_burst(4'h6, 32'h200, 8'd7, 3'd2, 2'b01, 8, 1'b1);
        check("toggle_nreq", 32'(mem_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check_beat("toggle_b", i, 4'h6, DXOR ^ (32'h200 + 32'(4 * i)), 2'b00, (i == 7));
        check("credit_violations", 32'(viol), 32'd0);

        // Memory error on beat 2 of 4
        err_at = 1;
        run_burst(4'h7, 32'h300, 8'd3, 3'd2, 2'b01, 4, 1'b0);
        err_at = -1;
        check_beat("err_b0", 0, 4'h7, 32'hA5A5_0300, 2'b00, 1'b0);
        check_beat("err_b1", 1, 4'h7, 32'hA5A5_0304, 2'b10, 1'b0);
        check_beat("err_b2", 2, 4'h7, 32'hA5A5_0308, 2'b00, 1'b0);
        check_beat("err_b3", 3, 4'h7, 32'hA5A5_030C, 2'b00, 1'b1);

        // Reset in the middle of a stalled burst
        r_ready_i = 1'b0;
        send_ar(4'h4, 32'h500, 8'd15, 3'd2, 2'b01);
        repeat (6) @(posedge clk_i);
        #1;
        check("stall_r_valid", 32'(r_valid_o), 32'd1);
        check("stall_ar_ready", 32'(ar_ready_o), 32'd0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_r_valid", 32'(r_valid_o), 32'd0);
        check("midrst_ar_ready", 32'(ar_ready_o), 32'd1);
        check("midrst_mem_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        r_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("after_rst_r_valid", 32'(r_valid_o), 32'd0);
        check("after_rst_ar_ready", 32'(ar_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Single-beat burst after reset starts clean
        run_burst(4'h9, 32'h404, 8'd0, 3'd2, 2'b01, 1, 1'b0);
        check("len0_nreq", 32'(mem_q.size()), 32'd1);
        check_addr("len0_a0", 0, 32'h404);
        check_beat("len0_b0", 0, 4'h9, 32'hA5A5_0404, 2'b00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
